// File: rtl/seg595_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// seg595_pkg : shared constants, types and digit encoder for seg_595_scan
// rev 1.0
// ----------------------------------------------------------------------
package seg595_pkg;

    localparam int N_DIGITS = 6;
    localparam int WORD_W   = 14;

    // Active-low segment codes, dp on bit 7
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } shift_state_t;

    typedef logic [N_DIGITS-1:0][7:0] frame_t;

    typedef struct packed {
        logic [4*N_DIGITS-1:0] bcd;
        logic [N_DIGITS-1:0]   point;
        logic                  sign;
        logic                  seg_en;
    } conv_t;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_595_scan_bin2bcd.sv
`default_nettype none
// ----------------------------------------------------------------------
// bin2bcd_seq : free-running 20-bit to 6-digit BCD shift-add-3 converter
// rev 1.0
// ----------------------------------------------------------------------
module bin2bcd_seq
    import seg595_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic        done,
    output conv_t       result
);

    localparam logic [19:0] SAT_MAX = 20'd999_999;

    logic [4:0]  iter;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [23:0] bcd_adj;
    logic [5:0]  point_s;
    logic        sign_s;
    logic        seg_en_s;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // iter 0 is the load cycle; iterations 1..20 shift one binary bit each
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter     <= 5'd0;
            bin      <= '0;
            bcd      <= '0;
            point_s  <= '0;
            sign_s   <= 1'b0;
            seg_en_s <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (iter == 5'd0) begin
                bin      <= (data > SAT_MAX) ? SAT_MAX : data;
                bcd      <= '0;
                point_s  <= point;
                sign_s   <= sign;
                seg_en_s <= seg_en;
                iter     <= 5'd1;
            end else begin
                bcd <= {bcd_adj[22:0], bin[19]};
                bin <= {bin[18:0], 1'b0};
                if (iter == 5'd20) begin
                    iter <= 5'd0;
                    done <= 1'b1;
                end else begin
                    iter <= iter + 5'd1;
                end
            end
        end
    end

    assign result = '{bcd: bcd, point: point_s, sign: sign_s, seg_en: seg_en_s};

endmodule
`default_nettype wire

// File: rtl/seg_595_scan.sv
`default_nettype none
// ----------------------------------------------------------------------
// seg_595_scan : six-digit seven-segment scanner driving a 74HC595 chain
// rev 1.0
// ----------------------------------------------------------------------
module seg_595_scan
    import seg595_pkg::*;
#(
    parameter int CNT_1MS_MAX = 49_999
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic        stcp,
    output logic        shcp,
    output logic        ds,
    output logic        oe
);

    localparam int CW = $clog2(CNT_1MS_MAX + 1);

    logic [CW-1:0]     dwell;
    logic [2:0]        digit;
    logic              tick;
    logic              conv_done;
    conv_t             conv_res;
    conv_t             latest;
    frame_t            disp;
    frame_t            fresh;
    logic [7:0]        seg_cur;
    logic [5:0]        sel_cur;
    logic [WORD_W-1:0] word_next;

    shift_state_t      state;
    logic [WORD_W-1:0] word;
    logic [1:0]        phase;
    logic [3:0]        bit_idx;
    logic              hold;

    bin2bcd_seq u_bcd (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .data   (data),
        .point  (point),
        .sign   (sign),
        .seg_en (seg_en),
        .done   (conv_done),
        .result (conv_res)
    );

    function automatic frame_t frame_codes(input conv_t c);
        frame_t              f;
        logic [N_DIGITS-1:0] blank;
        logic                live;
        logic                sign_used;
        logic [7:0]          code;
        f         = '0;
        blank     = '0;
        live      = 1'b0;
        sign_used = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            live     = live | (c.bcd[4*k +: 4] != 4'd0) | c.point[k] | (k == 0);
            blank[k] = !live;
        end
        // Blank digits form a contiguous top run, so the first one met is the sign slot
        for (int k = 0; k < N_DIGITS; k++) begin
            if (!blank[k]) begin
                code = seg_of(c.bcd[4*k +: 4]);
            end else if (c.sign && !sign_used) begin
                code      = SEG_MINUS;
                sign_used = 1'b1;
            end else begin
                code = SEG_BLANK;
            end
            if (c.point[k])
                code[7] = 1'b0;
            if (!c.seg_en)
                code = SEG_BLANK;
            f[k] = code;
        end
        return f;
    endfunction

    assign tick  = (dwell == CW'(CNT_1MS_MAX));
    assign fresh = frame_codes(latest);

    // Digit 0 uses the frame being loaded this very tick
    assign seg_cur   = (digit == 3'd0) ? fresh[0] : disp[digit];
    assign sel_cur   = 6'b000001 << digit;
    assign word_next = {seg_cur, sel_cur};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dwell  <= '0;
            digit  <= 3'd0;
            latest <= '0;
            disp   <= {N_DIGITS{SEG_BLANK}};
        end else begin
            if (tick) begin
                dwell <= '0;
                digit <= (digit == 3'(N_DIGITS - 1)) ? 3'd0 : digit + 3'd1;
                if (digit == 3'd0)
                    disp <= fresh;
            end else begin
                dwell <= dwell + CW'(1);
            end
            if (conv_done)
                latest <= conv_res;
        end
    end

    // Each bit spans phases 0..3: ds set on entry to phase 0, shcp high in 2 and 3
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            word    <= '0;
            phase   <= 2'd0;
            bit_idx <= 4'd0;
            hold    <= 1'b0;
            ds      <= 1'b0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            oe      <= 1'b1;
        end else begin
            oe <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state   <= SHIFT;
                        word    <= word_next;
                        ds      <= word_next[0];
                        phase   <= 2'd0;
                        bit_idx <= 4'd0;
                        shcp    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (phase == 2'd3) begin
                        shcp  <= 1'b0;
                        phase <= 2'd0;
                        if (bit_idx == 4'(WORD_W - 1)) begin
                            state <= LATCH;
                            stcp  <= 1'b1;
                            hold  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            ds      <= word[bit_idx + 4'd1];
                        end
                    end else begin
                        phase <= phase + 2'd1;
                        shcp  <= (phase >= 2'd1);
                    end
                end
                LATCH: begin
                    if (hold) begin
                        state <= IDLE;
                        stcp  <= 1'b0;
                    end else begin
                        hold <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    shcp  <= 1'b0;
                    stcp  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
